ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_pkg.sv | 46 ++++
 rtl/bram.sv | 74 +++++++
 rtl/ras_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ras_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// -----------------------------------------------------------------------------
// ras_pkg
//   Shared definitions for the return-address-stack controller.
//
//   Contents:
//     RAS_DEPTH   default number of entries held in the backing BRAM
//     RAS_WIDTH   default return-address width
//     ras_cmd_e   stack command seen by the controller in a given cycle
//     decode_cmd  maps the raw push/pop strobes plus the empty flag onto a
//                 single ras_cmd_e
// -----------------------------------------------------------------------------
package ras_pkg;

  localparam int RAS_DEPTH = 1024;
  localparam int RAS_WIDTH = 32;

  // NOP     : neither push nor pop
  // PUSH    : push only, or push+pop on an empty stack
  // POP     : pop only (the controller still has to check for underflow)
  // REPLACE : push+pop on a non-empty stack, the top is swapped in place
  typedef enum logic [1:0] {
    NOP     = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    REPLACE = 2'd3
  } ras_cmd_e;

  // Push+pop on an empty stack has nothing to pop, so it degrades to a
  // plain push and never raises underflow.
  function automatic ras_cmd_e decode_cmd(input logic push,
                                          input logic pop,
                                          input logic empty);
    ras_cmd_e cmd;
    if (push && pop) begin
      cmd = empty ? PUSH : REPLACE;
    end else if (push) begin
      cmd = PUSH;
    end else if (pop) begin
      cmd = POP;
    end else begin
      cmd = NOP;
    end
    return cmd;
  endfunction

endpackage : ras_pkg

// File: rtl/bram.sv
// -----------------------------------------------------------------------------
// bram
//   Simple true-dual-port block RAM on a single clock. Both ports have a
//   registered read (data appears the cycle after the read enable) and a
//   synchronous write. Reads return the old contents when a port reads and
//   writes the same location in one cycle. If both ports write the same
//   location in one cycle, port B wins. Contents are never cleared.
//
//   Parameters:
//     DEPTH  number of words (power of two)
//     WIDTH  word width
//     OFS    constant offset added (mod DEPTH) to every address on both ports
//     INCR   extra offset added (mod DEPTH) to port B addresses only, for
//            callers that want port B to run a fixed distance ahead of A
//
//   Ports:
//     clk                          clock
//     wea / rea / addra / dia      port A write enable, read enable, address,
//     doa                          write data, registered read data
//     web / reb / addrb / dib      port B, same meaning
//     dob
// -----------------------------------------------------------------------------
module bram
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = RAS_WIDTH,
  parameter int OFS   = 0,
  parameter int INCR  = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wea,
  input  logic             rea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dia,
  output logic [WIDTH-1:0] doa,
  input  logic             web,
  input  logic             reb,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] dob
);

  localparam logic [AW-1:0] OFS_A = AW'(OFS);
  localparam logic [AW-1:0] OFS_B = AW'(OFS + INCR);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;

  // AW-bit addition wraps naturally modulo DEPTH.
  always_comb begin
    a_addr = addra + OFS_A;
    b_addr = addrb + OFS_B;
  end

  always_ff @(posedge clk) begin
    if (wea) begin
      mem[a_addr] <= dia;
    end
    if (rea) begin
      doa <= mem[a_addr];
    end
    if (web) begin
      mem[b_addr] <= dib;
    end
    if (reb) begin
      dob <= mem[b_addr];
    end
  end

endmodule : bram

// File: rtl/ras_ctrl.sv
// -----------------------------------------------------------------------------
// ras_ctrl
//   Return-address stack. The two most recent entries live in registers
//   (T = top, S = second); everything older lives in a BRAM addressed by a
//   write pointer wp that points at the next free slot. Total capacity is
//   DEPTH+2. Pushing onto a full stack silently overwrites the oldest entry
//   via the natural wrap of wp and pulses overflow.
//
//   A pop issues a BRAM read of the entry under S. The read data (dob) lands
//   one cycle later; until it has been folded into S, the pend flag marks dob
//   as the real second entry (S_eff). That lets a following pop take its new
//   top straight from dob, so back-to-back pops run with no bubbles.
//
//   Command priority: rst > flush > push/pop.
//
//   Parameters:
//     DEPTH  BRAM entries (power of two, >= 4)
//     WIDTH  return-address width
//
//   Ports:
//     clk        clock, all state on posedge
//     rst        synchronous active-high reset
//     push       push push_data this cycle
//     pop        pop the top entry this cycle
//     flush      discard all entries (wins over push/pop)
//     push_data  address to push
//     top_data   registered top of stack, valid only while top_valid=1
//     top_valid  stack non-empty
//     full       stack holds DEPTH+2 entries
//     overflow   one-cycle pulse after a push accepted while full
//     underflow  one-cycle pulse after a pop on an empty stack
//
//   Handshake: push/pop/flush are single-cycle strobes with no ready back-
//   pressure; every strobe is consumed in the cycle it is presented and its
//   effect is visible on the outputs the following cycle.
// -----------------------------------------------------------------------------
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = RAS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             top_valid,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  // count runs 0..DEPTH+2, so it needs room for DEPTH+3 distinct values.
  localparam int CW = $clog2(DEPTH + 3);
  localparam logic [CW-1:0] CAP = CW'(DEPTH + 2);

  // Architectural state
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] s_q;
  logic             pend_q;
  logic [AW-1:0]    wp_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;

  // Derived / combinational
  logic [WIDTH-1:0] dob;
  logic [WIDTH-1:0] unused_doa;
  logic [WIDTH-1:0] s_eff;
  logic [AW-1:0]    wp_dec;
  logic             empty;
  logic             is_full;
  ras_cmd_e         cmd;
  logic             bram_we;
  logic             bram_re;

  always_comb begin
    empty   = (count_q == '0);
    is_full = (count_q == CAP);
    cmd     = decode_cmd(push, pop, empty);
    // While a pop's BRAM read is in flight, dob is the real second entry.
    s_eff   = pend_q ? dob : s_q;
    wp_dec  = wp_q - AW'(1);
    // BRAM traffic is suppressed under reset and flush so neither disturbs
    // stored contents or launches a read whose result would be discarded.
    bram_we = !rst && !flush && (cmd == PUSH);
    bram_re = !rst && !flush && (cmd == POP) && !empty;
  end

  // Port A only spills S_eff on a push; port B only refills on a pop.
  bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .OFS   (0),
    .INCR  (0)
  ) u_bram (
    .clk   (clk),
    .wea   (bram_we),
    .rea   (1'b0),
    .addra (wp_q),
    .dia   (s_eff),
    .doa   (unused_doa),
    .web   (1'b0),
    .reb   (bram_re),
    .addrb (wp_dec),
    .dib   ('0),
    .dob   (dob)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      s_q         <= '0;
      pend_q      <= 1'b0;   // drops any BRAM read still in flight
      wp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (flush) begin
        // T and S are left alone; with count=0 they are don't-care anyway.
        count_q <= '0;
        wp_q    <= '0;
        pend_q  <= 1'b0;
      end else begin
        case (cmd)
          PUSH: begin
            t_q    <= push_data;
            s_q    <= t_q;
            wp_q   <= wp_q + AW'(1);
            pend_q <= 1'b0;
            // When full, the wp wrap has just overwritten the oldest entry.
            if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          POP: begin
            if (empty) begin
              underflow_q <= 1'b1;
            end else begin
              t_q     <= s_eff;
              wp_q    <= wp_dec;
              pend_q  <= 1'b1;
              count_q <= count_q - CW'(1);
            end
          end
          REPLACE: begin
            t_q    <= push_data;
            s_q    <= s_eff;
            pend_q <= 1'b0;
          end
          default: begin
            // Idle: fold the landed read into S so dob is free again.
            if (pend_q) begin
              s_q    <= dob;
              pend_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    top_data  = t_q;
    top_valid = !empty;
    full      = is_full;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule : ras_ctrl

// File: tb/tb_ras_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ras_ctrl
//   Directed bench for ras_ctrl at DEPTH=4 (capacity 6), WIDTH=32.
//   A table of single-cycle vectors covers push/pop ordering, underflow,
//   replace, idle refill and flush; hand-written sequences cover overflow
//   wrap and reset during a pop.
// -----------------------------------------------------------------------------
module tb_ras_ctrl;

  localparam int D   = 4;
  localparam int W   = 32;
  localparam int CAP = D + 2;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         push;
  logic         pop;
  logic         flush;
  logic [W-1:0] push_data;
  logic [W-1:0] top_data;
  logic         top_valid;
  logic         full;
  logic         overflow;
  logic         underflow;

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(D), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .top_data  (top_data),
    .top_valid (top_valid),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         push;
    logic         pop;
    logic         flush;
    logic [W-1:0] data;
    logic         e_valid;
    logic [W-1:0] e_top;
    logic         e_full;
    logic         e_ovf;
    logic         e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic pu, input logic po,
                              input logic fl, input logic [W-1:0] d,
                              input logic ev, input logic [W-1:0] et,
                              input logic ef, input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.push = pu; v.pop = po; v.flush = fl; v.data = d;
    v.e_valid = ev; v.e_top = et; v.e_full = ef; v.e_ovf = eo; v.e_udf = eu;
    return v;
  endfunction

  // Driver: apply inputs, let one active edge pass, return 1 time unit later.
  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic fl, input logic [W-1:0] d);
    rst = r; push = pu; pop = po; flush = fl; push_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input int idx,
                           input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic check_word(input string name, input int idx,
                            input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    check_bit("top_valid", idx, top_valid, v.e_valid);
    check_bit("full", idx, full, v.e_full);
    check_bit("overflow", idx, overflow, v.e_ovf);
    check_bit("underflow", idx, underflow, v.e_udf);
    if (v.e_valid) begin
      check_word("top_data", idx, top_data, v.e_top);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;

    // ---- reset state ----
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    check_bit("rst_top_valid", 0, top_valid, 1'b0);
    check_bit("rst_full", 0, full, 1'b0);
    check_bit("rst_overflow", 0, overflow, 1'b0);
    check_bit("rst_underflow", 0, underflow, 1'b0);
    check_word("rst_top_data", 0, top_data, '0);

    // ---- vector table ----
    //          rst pu po fl data     ev etop     ef eo eu
    // basic order and back-to-back pops
    vecs.push_back(mk(0, 1, 0, 0, 'h10, 1, 'h10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h20, 1, 'h20, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h30, 1, 'h30, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h20, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    // underflow: one-cycle pulse
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0));
    // replace keeps count; push+pop when empty is a push
    vecs.push_back(mk(0, 1, 0, 0, 'h0A, 1, 'h0A, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 'h0B, 1, 'h0B, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 'h0C, 1, 'h0C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    // push right after a pop (read still pending)
    vecs.push_back(mk(0, 1, 0, 0, 'h01, 1, 'h01, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h02, 1, 'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h03, 1, 'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h09, 1, 'h09, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h02, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    // idle cycles after a pop, then pop again
    vecs.push_back(mk(0, 1, 0, 0, 'h11, 1, 'h11, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h22, 1, 'h22, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h33, 1, 'h33, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h22, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 1, 'h22, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 1, 'h22, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h11, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    // replace while a read is pending
    vecs.push_back(mk(0, 1, 0, 0, 'h41, 1, 'h41, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h42, 1, 'h42, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h43, 1, 'h43, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h42, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 'h44, 1, 'h44, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 1, 'h41, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 0));
    // flush wins over push and pop
    vecs.push_back(mk(0, 1, 0, 0, 'h05, 1, 'h05, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h06, 1, 'h06, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 'h07, 0, 'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h00, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 'h55, 1, 'h55, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h00, 0, 'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].data);
      check_vec(i + 1, vecs[i]);
    end

    // ---- overflow wrap: push 1..7 into a 6-deep stack, then pop all ----
    drive(1, 0, 0, 0, '0);
    exp_q.delete();
    for (int i = 1; i <= 7; i++) begin
      logic exp_ovf;
      exp_ovf = (exp_q.size() == CAP);
      if (exp_ovf) begin
        void'(exp_q.pop_front());
      end
      exp_q.push_back(W'(i));
      drive(0, 1, 0, 0, W'(i));
      check_word("ovf_push_top", 100 + i, top_data, exp_q[exp_q.size() - 1]);
      check_bit("ovf_push_full", 100 + i, full, exp_q.size() == CAP);
      check_bit("ovf_push_pulse", 100 + i, overflow, exp_ovf);
    end
    drive(0, 0, 0, 0, '0);
    check_bit("ovf_pulse_end", 108, overflow, 1'b0);
    for (int i = 0; i < CAP; i++) begin
      void'(exp_q.pop_back());
      drive(0, 0, 1, 0, '0);
      check_bit("ovf_pop_valid", 110 + i, top_valid, exp_q.size() != 0);
      check_bit("ovf_pop_full", 110 + i, full, 1'b0);
      if (exp_q.size() != 0) begin
        check_word("ovf_pop_top", 110 + i, top_data, exp_q[exp_q.size() - 1]);
      end
    end

    // ---- reset while a pop is issued ----
    drive(0, 1, 0, 0, 'h61);
    drive(0, 1, 0, 0, 'h62);
    drive(0, 1, 0, 0, 'h63);
    check_word("pre_rst_top", 200, top_data, 'h63);
    drive(1, 0, 1, 0, '0);
    check_bit("rst_pop_valid", 201, top_valid, 1'b0);
    check_word("rst_pop_top", 201, top_data, '0);
    check_bit("rst_pop_udf", 201, underflow, 1'b0);
    drive(0, 0, 0, 0, '0);
    check_bit("rst_idle_udf", 202, underflow, 1'b0);
    check_bit("rst_idle_valid", 202, top_valid, 1'b0);
    for (int i = 1; i <= CAP; i++) begin
      drive(0, 1, 0, 0, W'('h70 + i));
      check_bit("rst_refill_full", 210 + i, full, i == CAP);
      check_bit("rst_refill_ovf", 210 + i, overflow, 1'b0);
    end
    drive(0, 0, 1, 0, '0);
    check_word("rst_pop1_top", 220, top_data, 'h75);
    drive(0, 0, 1, 0, '0);
    check_word("rst_pop2_top", 221, top_data, 'h74);
    drive(0, 0, 1, 0, '0);
    check_word("rst_pop3_top", 222, top_data, 'h73);
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ras_ctrl
